// File: rtl/rvga_pipe_ctrl_pkg.sv
// rvga_types: shared types and defaults for the rvga pipeline controller.
//   rvga_fetch_state_e      - fetch-side FSM state (RUN / SQUASH)
//   RVGA_NUM_STAGES_DEFAULT - default pipeline depth
package rvga_types;

  localparam int RVGA_NUM_STAGES_DEFAULT = 6;

  // RUN    : fetch responses are accepted into stage 0
  // SQUASH : one stale fetch response is still in flight and must be dropped
  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } rvga_fetch_state_e;

endpackage

// File: rtl/rvga_pipe_ctrl_perf_cnt.sv
// rvga_perf_cnt: free-running wrapping event counter.
//   clk_i  - clock
//   clr_ni - synchronous active-low clear
//   en_i   - count enable, +1 per cycle while high
//   cnt_o  - current count, wraps modulo 2^CNT_W
module rvga_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = en_i ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk_i) begin
    if (!clr_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rvga_pipe_ctrl.sv
// rvga_pipe_ctrl: N-stage pipeline controller for the rvga core.
// Owns the per-stage valid bits, derives stall/flush for every stage,
// drops stale fetch responses after a redirect and keeps perf counters.
//   clk_i, rst_i        - clock, synchronous active-low reset
//   imem_resp_v_i       - instruction fetch response valid
//   dmem_req_v_i/resp_v - MEM_STAGE access outstanding / data response valid
//   hold_i              - per-stage external hold requests
//   br_taken_i          - instruction in BR_STAGE is a taken branch
//   stage_v_o           - per-stage live-instruction flags
//   stall_o, flush_o    - per-stage hold / invalidate controls
//   redirect_o          - fetch loads branch target this cycle
//   retire_v_o          - instruction leaves the last stage this cycle
//   *_cnt_o             - retire / stage-0 stall / redirect counters
module rvga_pipe_ctrl
  import rvga_types::*;
#(
  parameter int NUM_STAGES = RVGA_NUM_STAGES_DEFAULT,
  parameter int MEM_STAGE  = 4,
  parameter int BR_STAGE   = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  imem_resp_v_i,
  input  logic                  dmem_req_v_i,
  input  logic                  dmem_resp_v_i,
  input  logic [NUM_STAGES-1:0] hold_i,
  input  logic                  br_taken_i,
  output logic [NUM_STAGES-1:0] stage_v_o,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  redirect_o,
  output logic                  retire_v_o,
  output logic [CNT_W-1:0]      retire_cnt_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  // Parameter legality
  if (NUM_STAGES < 3 || NUM_STAGES > 16) begin : g_bad_num_stages
    $error("rvga_pipe_ctrl: NUM_STAGES must be in 3..16");
  end
  if (MEM_STAGE < 1 || MEM_STAGE >= NUM_STAGES) begin : g_bad_mem_stage
    $error("rvga_pipe_ctrl: MEM_STAGE must be in 1..NUM_STAGES-1");
  end
  if (BR_STAGE < 1 || BR_STAGE >= NUM_STAGES) begin : g_bad_br_stage
    $error("rvga_pipe_ctrl: BR_STAGE must be in 1..NUM_STAGES-1");
  end

  logic [NUM_STAGES-1:0] stage_v_q, stage_v_d;
  logic [NUM_STAGES-1:0] raw, stall, flush;
  logic                  stall_acc;
  logic                  dmem_wait, br_fire, fetch_accept, retire_v;
  rvga_fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0]      retire_cnt, stall_cnt, flush_cnt;

  // Raw stall sources; the memory stage also waits on an outstanding access.
  assign dmem_wait = stage_v_q[MEM_STAGE] & dmem_req_v_i & ~dmem_resp_v_i;

  always_comb begin
    raw            = hold_i;
    raw[MEM_STAGE] = hold_i[MEM_STAGE] | dmem_wait;
  end

  // A stall freezes its own stage and every older (lower-index) stage.
  always_comb begin
    stall_acc = 1'b0;
    stall     = '0;
    for (int k = NUM_STAGES-1; k >= 0; k--) begin
      stall_acc = stall_acc | raw[k];
      stall[k]  = stall_acc;
    end
  end

  // A branch held by a stall waits, so it fires exactly once on release.
  assign br_fire = stage_v_q[BR_STAGE] & br_taken_i & ~stall[BR_STAGE];

  always_comb begin
    flush = '0;
    for (int k = 0; k < NUM_STAGES; k++) flush[k] = br_fire && (k < BR_STAGE);
  end

  // Fetch FSM: after a redirect with no response in hand, the response to the
  // old request is still coming and must not enter stage 0.
  always_comb begin
    state_d      = state_q;
    fetch_accept = 1'b0;
    unique case (state_q)
      RUN: begin
        fetch_accept = imem_resp_v_i & ~stall[0] & ~br_fire;
        if (br_fire && !imem_resp_v_i) state_d = SQUASH;
      end
      SQUASH: begin
        if (!br_fire && imem_resp_v_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Valid-bit advance. Flush wins over stall; a stage whose predecessor is
  // stalled while it moves on receives a bubble.
  always_comb begin
    stage_v_d = stage_v_q;
    if (flush[0])       stage_v_d[0] = 1'b0;
    else if (!stall[0]) stage_v_d[0] = fetch_accept;
    for (int k = 1; k < NUM_STAGES; k++) begin
      if (flush[k])       stage_v_d[k] = 1'b0;
      else if (!stall[k]) stage_v_d[k] = stage_v_q[k-1] & ~stall[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stage_v_q <= '0;
      state_q   <= RUN;
    end else begin
      stage_v_q <= stage_v_d;
      state_q   <= state_d;
    end
  end

  assign retire_v = stage_v_q[NUM_STAGES-1] & ~stall[NUM_STAGES-1];

  rvga_perf_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_i),
    .en_i   (retire_v),
    .cnt_o  (retire_cnt)
  );

  rvga_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_i),
    .en_i   (stall[0]),
    .cnt_o  (stall_cnt)
  );

  rvga_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_i),
    .en_i   (br_fire),
    .cnt_o  (flush_cnt)
  );

  // Everything reads as zero while reset is asserted, including the first
  // reset cycle before state has been cleared.
  assign stage_v_o    = {NUM_STAGES{rst_i}} & stage_v_q;
  assign stall_o      = {NUM_STAGES{rst_i}} & stall;
  assign flush_o      = {NUM_STAGES{rst_i}} & flush;
  assign redirect_o   = rst_i & br_fire;
  assign retire_v_o   = rst_i & retire_v;
  assign retire_cnt_o = rst_i ? retire_cnt : '0;
  assign stall_cnt_o  = rst_i ? stall_cnt  : '0;
  assign flush_cnt_o  = rst_i ? flush_cnt  : '0;

endmodule

// File: tb/tb_rvga_pipe_ctrl.sv
module tb_rvga_pipe_ctrl;

  localparam int NS  = 6;
  localparam int MEM = 4;
  localparam int BR  = 5;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          imem_resp_v_i = 1'b0, dmem_req_v_i = 1'b0, dmem_resp_v_i = 1'b0;
  logic [NS-1:0] hold_i = '0;
  logic          br_taken_i = 1'b0;
  logic [NS-1:0] stage_v_o, stall_o, flush_o;
  logic          redirect_o, retire_v_o;
  logic [CW-1:0] retire_cnt_o, stall_cnt_o, flush_cnt_o;

  rvga_pipe_ctrl #(.NUM_STAGES(NS), .MEM_STAGE(MEM), .BR_STAGE(BR), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_resp_v_i(imem_resp_v_i), .dmem_req_v_i(dmem_req_v_i), .dmem_resp_v_i(dmem_resp_v_i),
    .hold_i(hold_i), .br_taken_i(br_taken_i),
    .stage_v_o(stage_v_o), .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .retire_v_o(retire_v_o),
    .retire_cnt_o(retire_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Occupancy per stage, a "stale response pending" flag and plain event
  // totals. Stall extent is the highest stalling stage index.
  bit [NS-1:0] m_v, n_v;
  bit          m_sq, n_sq;
  int          m_ret, m_stl, m_fl, n_ret, n_stl, n_fl;
  bit [NS-1:0] e_v, e_stall, e_flush;
  bit          e_redir, e_ret;

  task automatic model_eval(input bit rst, imem, dreq, dresp, input bit [NS-1:0] hold, input bit br);
    int  hi;
    bit  fire, ret, acc;
    hi = -1;
    for (int k = 0; k < NS; k++)
      if (hold[k] || (k == MEM && m_v[MEM] && dreq && !dresp)) hi = k;
    fire = m_v[BR] && br && (hi < BR);
    ret  = m_v[NS-1] && (hi < NS-1);
    acc  = !m_sq && imem && (hi < 0) && !fire;
    if (!rst) begin
      e_v = '0; e_stall = '0; e_flush = '0; e_redir = 0; e_ret = 0;
      n_v = '0; n_sq = 0; n_ret = 0; n_stl = 0; n_fl = 0;
      return;
    end
    e_v     = m_v;
    e_stall = (hi < 0) ? '0 : NS'((32'd1 << (hi + 1)) - 1);
    e_flush = fire ? NS'((32'd1 << BR) - 1) : '0;
    e_redir = fire;
    e_ret   = ret;
    // Stages up to hi freeze; slot hi+1 receives a bubble (or the fetch when
    // nothing stalls); everything above shifts up by one.
    for (int k = 0; k < NS; k++) begin
      if (k <= hi)          n_v[k] = m_v[k];
      else if (k == hi + 1) n_v[k] = (k == 0) ? acc : 1'b0;
      else                  n_v[k] = m_v[k-1];
    end
    if (fire) for (int k = 0; k < BR; k++) n_v[k] = 1'b0;
    if (fire)                n_sq = m_sq | !imem;
    else if (m_sq && imem)   n_sq = 0;
    else                     n_sq = m_sq;
    n_ret = m_ret + int'(ret);
    n_stl = m_stl + int'(hi >= 0);
    n_fl  = m_fl + int'(fire);
  endtask

  task automatic step(input bit rst, imem, dreq, dresp, input bit [NS-1:0] hold, input bit br);
    @(negedge clk);
    rst_i = rst; imem_resp_v_i = imem; dmem_req_v_i = dreq; dmem_resp_v_i = dresp;
    hold_i = hold; br_taken_i = br;
    #2;
    model_eval(rst, imem, dreq, dresp, hold, br);
    chk("stage_v",    stage_v_o,    e_v);
    chk("stall",      stall_o,      e_stall);
    chk("flush",      flush_o,      e_flush);
    chk("redirect",   redirect_o,   e_redir);
    chk("retire_v",   retire_v_o,   e_ret);
    chk("retire_cnt", retire_cnt_o, rst ? m_ret % 256 : 0);
    chk("stall_cnt",  stall_cnt_o,  rst ? m_stl % 256 : 0);
    chk("flush_cnt",  flush_cnt_o,  rst ? m_fl % 256 : 0);
    m_v = n_v; m_sq = n_sq; m_ret = n_ret; m_stl = n_stl; m_fl = n_fl;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, imem, dreq, dresp; bit [NS-1:0] hold; bit br;
    bit [NS-1:0] v, stl, fl; bit redir, ret; bit [CW-1:0] rcnt, scnt, fcnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rst, imem, dreq, dresp, bit [NS-1:0] hold, bit br,
                              bit [NS-1:0] v, stl, fl, bit redir, ret,
                              bit [CW-1:0] rcnt, scnt, fcnt);
    vec_t r;
    r.rst = rst; r.imem = imem; r.dreq = dreq; r.dresp = dresp; r.hold = hold; r.br = br;
    r.v = v; r.stl = stl; r.fl = fl; r.redir = redir; r.ret = ret;
    r.rcnt = rcnt; r.scnt = scnt; r.fcnt = fcnt;
    tbl.push_back(r);
  endfunction

  initial begin
    int fc0;
    // reset: outputs forced low even with active inputs
    add(0,1,0,0,6'h3F,1, 6'h00,6'h00,6'h00,0,0, 0,0,0);
    add(0,0,0,0,6'h00,0, 6'h00,6'h00,6'h00,0,0, 0,0,0);
    // fill and retire
    for (int c = 0; c < 10; c++)
      add(1,1,0,0,6'h00,0, (c >= 6) ? 6'h3F : NS'((1 << c) - 1), 6'h00,6'h00,0, c >= 6,
          CW'((c > 6) ? c - 6 : 0), 0, 0);
    // data-memory stall for 3 cycles, then response
    add(1,1,1,0,6'h00,0, 6'h3F,6'h1F,6'h00,0,1, 4,0,0);
    add(1,1,1,0,6'h00,0, 6'h1F,6'h1F,6'h00,0,0, 5,1,0);
    add(1,1,1,0,6'h00,0, 6'h1F,6'h1F,6'h00,0,0, 5,2,0);
    add(1,1,1,1,6'h00,0, 6'h1F,6'h00,6'h00,0,0, 5,3,0);
    add(1,1,0,0,6'h00,0, 6'h3F,6'h00,6'h00,0,1, 5,3,0);
    // redirect with response present
    add(1,1,0,0,6'h00,1, 6'h3F,6'h00,6'h1F,1,1, 6,3,0);
    add(1,1,0,0,6'h00,0, 6'h20,6'h00,6'h00,0,1, 7,3,1);
    add(1,0,0,0,6'h00,0, 6'h01,6'h00,6'h00,0,0, 8,3,1);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].imem, tbl[i].dreq, tbl[i].dresp, tbl[i].hold, tbl[i].br);
      chk($sformatf("tbl_v[%0d]", i),     stage_v_o,    tbl[i].v);
      chk($sformatf("tbl_stall[%0d]", i), stall_o,      tbl[i].stl);
      chk($sformatf("tbl_flush[%0d]", i), flush_o,      tbl[i].fl);
      chk($sformatf("tbl_redir[%0d]", i), redirect_o,   tbl[i].redir);
      chk($sformatf("tbl_ret[%0d]", i),   retire_v_o,   tbl[i].ret);
      chk($sformatf("tbl_rcnt[%0d]", i),  retire_cnt_o, tbl[i].rcnt);
      chk($sformatf("tbl_scnt[%0d]", i),  stall_cnt_o,  tbl[i].scnt);
      chk($sformatf("tbl_fcnt[%0d]", i),  flush_cnt_o,  tbl[i].fcnt);
    end

    // squash path: redirect with no response, stale response dropped
    repeat (6) step(1,1,0,0,'0,0);
    step(1,0,0,0,'0,1);
    chk("sq_redirect", redirect_o, 1);
    step(1,0,0,0,'0,0);
    step(1,1,0,0,'0,0);            // stale response
    step(1,0,0,0,'0,0);
    chk("sq_drop", stage_v_o[0], 0);
    step(1,1,0,0,'0,0);            // fresh response
    step(1,0,0,0,'0,0);
    chk("sq_accept", stage_v_o[0], 1);

    // branch held in BR_STAGE fires once, on release
    repeat (6) step(1,1,0,0,'0,0);
    fc0 = m_fl;
    step(1,0,0,0,6'h20,1);
    chk("sb_hold0", redirect_o, 0);
    step(1,0,0,0,6'h20,1);
    chk("sb_hold1", redirect_o, 0);
    step(1,0,0,0,6'h00,1);
    chk("sb_fire", redirect_o, 1);
    step(1,0,0,0,6'h00,0);
    chk("sb_once", redirect_o, 0);
    chk("sb_fcnt", flush_cnt_o, (fc0 + 1) % 256);

    // reset while squashing with stalls asserted
    repeat (6) step(1,1,0,0,'0,0);
    step(1,0,0,0,'0,1);
    step(0,1,1,0,6'h3F,1);
    chk("rst_stall", stall_o, 0);
    step(0,0,0,0,'0,0);
    step(1,1,0,0,'0,0);
    chk("rst_v", stage_v_o, 0);
    chk("rst_rcnt", retire_cnt_o, 0);
    step(1,1,0,0,'0,0);
    chk("rst_no_squash", stage_v_o, 6'h01);

    // retire counter wrap
    for (int i = 0; i < 400 && m_ret < 256; i++) step(1,1,0,0,'0,0);
    chk("wrap_budget", m_ret, 256);
    @(posedge clk); #1;
    chk("wrap", retire_cnt_o, 0);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bit [NS-1:0] h;
      h = '0;
      for (int k = 0; k < NS; k++) h[k] = ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 63) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 1) == 1, h, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
